ahb_slave_bridge: RTL and testbench
===================================

# ahb_slave_bridge

Parametrised AHB-Lite slave that bridges AHB transfers onto a simple strobe-based external peripheral interface. It generalises the team's first AHB slave: configurable data width with byte-lane strobes, external wait states, a wait-state timeout, and a two-cycle AHB ERROR response for peripheral abort, bad size or misalignment. It sits between the AHB interconnect (one HSELx slot) and a single peripheral register block.

## Interface
- AddresseWidth, 16, HADDR / AddressOUT width.
- DataWidth, 32, HWDATA/HRDATA/data width; one of 8, 16, 32, 64.
- TimeoutCycles, 16, max wait cycles per data phase before ERROR; 0 disables the timeout.

- HCLK  in  1  clock, all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSELx  in  1  slave select.
- HADDR  in  AddresseWidth  address-phase address.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, bytes = 1 << HSIZE.
- HBURST  in  3  burst type; accepted, not used for address generation.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  in  1  bus-wide ready; address phase is sampled only when 1.
- HWDATA  in  DataWidth  write data, valid in data phase.
- HREADYOUT  out  1  transfer done / wait-state control.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DataWidth  read data.
- Write  out  1  external write strobe.
- Read  out  1  external read strobe.
- AddressOUT  out  AddresseWidth  external address.
- OutputData  out  DataWidth  external write data.
- ByteEn  out  DataWidth/8  active byte lanes, little-endian.
- InData  in  DataWidth  external read data.
- ValidRead  in  1  InData valid; completes a read.
- ReadyToWork  in  1  peripheral accepted the write; completes a write.
- StopOp  in  1  peripheral abort; forces ERROR.

## Operation
- States: IDLE, WDATA, RDATA, ERR1, ERR2.
- Accept: HSELx & HREADY & HTRANS[1] registers HADDR, HWRITE, HSIZE and the byte-lane mask. IDLE/BUSY transfers, or no HSELx, return OKAY with zero wait and no strobes.
- Check at accept: HSIZE > log2(DataWidth/8), or HADDR not aligned to 1<<HSIZE -> next state ERR1. No strobe is issued.
- Otherwise, next state is WDATA (write) or RDATA (read).
- ByteEn: (1<<HSIZE) ones shifted left by HADDR[log2(DataWidth/8)-1:0]. It is registered and held for the whole data phase.
- WDATA: Write=1, AddressOUT = registered address, OutputData = HWDATA (combinational pass-through), HREADYOUT = ReadyToWork, HRESP=0.
- RDATA: Read=1, HREADYOUT = ValidRead, HRDATA = ValidRead ? InData : 0.
- Per data-phase cycle, priority is StopOp > handshake > timeout.
  - StopOp=1 -> ERR1. The strobe is low from the next cycle.
  - Handshake -> complete. If a new transfer is accepted in the same cycle, go to WDATA/RDATA/ERR1; otherwise go to IDLE.
- Timeout: a wait counter clears on entering WDATA/RDATA and increments on each HREADYOUT=0 cycle. When it reaches TimeoutCycles without a handshake -> ERR1.
- ERR1: HREADYOUT=0, HRESP=1, strobes 0.
- ERR2: HREADYOUT=1, HRESP=1. New accepts are allowed (HREADY=1); otherwise go to IDLE. A master cancelling with HTRANS=IDLE in ERR2 gets no transfer.
- HRDATA is 0 in every state and cycle except an RDATA cycle with ValidRead=1.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, Write=0, Read=0, AddressOUT=0, ByteEn=0, OutputData=0, wait counter 0.
- HRESET wins over every other input. Reset mid data phase drops strobes at the next edge, with no ERROR issued.
- Latency: strobe is asserted in the cycle after the address phase. A zero-wait transfer completes in that same cycle.
- Wait states: the strobe and AddressOUT stay stable while HREADYOUT=0.
- Pipelined back-to-back transfers need no idle cycle.
- The error response is exactly 2 cycles, with HRESP=1 in both.
- With TimeoutCycles=N, the maximum data phase before ERROR is N wait cycles, plus ERR1 and ERR2.

## Test plan
Configuration: DataWidth=32, AddresseWidth=16, TimeoutCycles=4.
- Single write: NONSEQ write, HADDR=0x00A4, HSIZE=2, HWDATA=0x12345678, ReadyToWork=1.
  - Next cycle: Write=1, Read=0, AddressOUT=0x00A4, OutputData=0x12345678, ByteEn=4'hF, HREADYOUT=1, HRESP=0.
- Read with waits: NONSEQ read 0x0010, ValidRead low for 2 cycles, then high with InData=0xDEADBEEF.
  - Read=1 for 3 cycles, HREADYOUT=0,0,1, HRDATA=0xDEADBEEF in the final cycle and 0 before it.
- Byte lanes and alignment:
  - Byte write to 0x0003 -> ByteEn=4'b1000.
  - Halfword to 0x0001 -> HREADYOUT/HRESP = 0/1 then 1/1, Write never asserted.
  - HSIZE=3 -> same ERROR.
- Timeout and abort:
  - Read with ValidRead held 0 -> 4 wait cycles, then ERR1, ERR2; Read=0 from ERR1.
  - Write with StopOp=1 in its first data cycle -> ERROR response, Write low next cycle.
- Pipelined accesses: write 0x0020 (data 0xA5A5A5A5), then read 0x0024 in its data phase, then IDLE.
  - Write strobe, then Read strobe, on consecutive cycles with no gap.
  - BUSY with HSELx=1 -> OKAY, no strobe.
- Reset mid-operation: HRESET=1 during the WDATA wait state.
  - Next edge: Write=0, HREADYOUT=1, HRESP=0, AddressOUT=0.
  - A following write to 0x0008 works normally.

Source files
------------

// File: rtl/ahb_slave_bridge_if.sv
// ahb_slave_bridge_if: AHB-Lite slave bus plus strobe-based peripheral signals
interface ahb_slave_bridge_if #(
    parameter int AddresseWidth = 16,
    parameter int DataWidth = 32
);
    logic                     HSELx;
    logic [AddresseWidth-1:0] HADDR;
    logic                     HWRITE;
    logic [2:0]               HSIZE;
    logic [2:0]               HBURST;
    logic [1:0]               HTRANS;
    logic                     HREADY;
    logic [DataWidth-1:0]     HWDATA;
    logic                     HREADYOUT;
    logic                     HRESP;
    logic [DataWidth-1:0]     HRDATA;
    logic                     Write;
    logic                     Read;
    logic [AddresseWidth-1:0] AddressOUT;
    logic [DataWidth-1:0]     OutputData;
    logic [DataWidth/8-1:0]   ByteEn;
    logic [DataWidth-1:0]     InData;
    logic                     ValidRead;
    logic                     ReadyToWork;
    logic                     StopOp;
    modport slave (
        input  HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
               InData, ValidRead, ReadyToWork, StopOp,
        output HREADYOUT, HRESP, HRDATA, Write, Read, AddressOUT, OutputData, ByteEn
    );
    modport master (
        output HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
               InData, ValidRead, ReadyToWork, StopOp,
        input  HREADYOUT, HRESP, HRDATA, Write, Read, AddressOUT, OutputData, ByteEn
    );
endinterface

// File: rtl/ahb_slave_bridge.sv
// ahb_slave_bridge: AHB-Lite slave bridging transfers onto a strobe-based peripheral port
module ahb_slave_bridge #(
    parameter int AddresseWidth = 16,
    parameter int DataWidth = 32,
    parameter int TimeoutCycles = 16
) (
    input logic HCLK,
    input logic HRESET,
    ahb_slave_bridge_if.slave bus
);
    localparam int NB = DataWidth / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = TimeoutCycles > 1 ? $clog2(TimeoutCycles + 1) : 1;
    typedef enum logic [2:0] {IDLE, WDATA, RDATA, ERR1, ERR2} state_t;
    state_t state, nxt, tgt;
    logic [AddresseWidth-1:0] addr_q;
    logic [NB-1:0] be_q, be_d;
    logic [CW-1:0] wcnt;
    logic acc, bad, hs, tmo, dp, ld;
    int off;
    always_comb begin
        dp = state == WDATA || state == RDATA;
        hs = (state == WDATA && bus.ReadyToWork) || (state == RDATA && bus.ValidRead);
        bus.Write = state == WDATA;
        bus.Read = state == RDATA;
        bus.HREADYOUT = dp ? hs : state != ERR1;
        bus.HRESP = state == ERR1 || state == ERR2;
        bus.HRDATA = state == RDATA && bus.ValidRead ? bus.InData : '0;
        bus.AddressOUT = dp ? addr_q : '0;
        bus.ByteEn = dp ? be_q : '0;
        bus.OutputData = state == WDATA ? bus.HWDATA : '0;
    end
    // Kept apart from the output block: HREADY can be a combinational copy of HREADYOUT.
    always_comb begin
        acc = bus.HSELx && bus.HREADY && bus.HTRANS[1];
        off = int'(bus.HADDR) % NB;
        bad = int'(bus.HSIZE) > LB || (int'(bus.HADDR) & ((1 << bus.HSIZE) - 1)) != 0;
        for (int i = 0; i < NB; i++) be_d[i] = i >= off && i < off + (1 << bus.HSIZE);
        tgt = bad ? ERR1 : bus.HWRITE ? WDATA : RDATA;
        tmo = TimeoutCycles != 0 && wcnt == CW'(TimeoutCycles - 1);
        nxt = state;
        ld = 1'b0;
        if (state == ERR1) nxt = ERR2;
        else if (dp && bus.StopOp) nxt = ERR1;
        else if (!dp || hs) begin
            nxt = acc ? tgt : IDLE;
            ld = acc;
        end
        else if (tmo) nxt = ERR1;
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
            addr_q <= '0;
            be_q <= '0;
            wcnt <= '0;
        end else begin
            state <= nxt;
            if (ld) begin
                addr_q <= bus.HADDR;
                be_q <= be_d;
            end
            wcnt <= ld ? '0 : dp && !hs ? wcnt + 1'b1 : wcnt;
        end
    end
endmodule

// File: tb/tb_ahb_slave_bridge.sv
// tb_ahb_slave_bridge: table-driven scoreboard bench for ahb_slave_bridge
module tb_ahb_slave_bridge;
    logic HCLK, HRESET;
    int checks = 0, errors = 0;
    ahb_slave_bridge_if #(.AddresseWidth(16), .DataWidth(32)) bus ();
    ahb_slave_bridge #(.AddresseWidth(16), .DataWidth(32), .TimeoutCycles(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
    );
    assign bus.HREADY = bus.HREADYOUT;
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end
    typedef struct {
        logic r, s;
        logic [1:0] t;
        logic w;
        logic [2:0] z;
        logic [15:0] a;
        logic [31:0] wd, id;
        logic v, k, p;
        logic [87:0] e;
    } vec_t;
    vec_t tab[$];
    logic [87:0] exp_q[$];
    function automatic logic [87:0] ex(logic rdy, logic resp, logic [31:0] rdata, logic w, logic r,
                                       logic [15:0] a, logic [3:0] b, logic [31:0] o);
        return {rdy, resp, rdata, w, r, a, b, o};
    endfunction
    function automatic vec_t mk(logic r, logic s, logic [1:0] t, logic w, logic [2:0] z, logic [15:0] a,
                                logic [31:0] wd, logic [31:0] id, logic v, logic k, logic p, logic [87:0] e);
        vec_t x;
        x = '{r, s, t, w, z, a, wd, id, v, k, p, e};
        return x;
    endfunction
    task automatic apply(input vec_t x);
        HRESET = x.r;
        bus.HSELx = x.s;
        bus.HTRANS = x.t;
        bus.HWRITE = x.w;
        bus.HSIZE = x.z;
        bus.HADDR = x.a;
        bus.HWDATA = x.wd;
        bus.InData = x.id;
        bus.ValidRead = x.v;
        bus.ReadyToWork = x.k;
        bus.StopOp = x.p;
        bus.HBURST = 3'd0;
    endtask
    task automatic chk(input string name, input logic [87:0] got, input logic [87:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask
    function automatic logic [87:0] outs();
        return {bus.HREADYOUT, bus.HRESP, bus.HRDATA, bus.Write, bus.Read, bus.AddressOUT, bus.ByteEn, bus.OutputData};
    endfunction
    initial begin
        logic [87:0] EI, EE1, EE2;
        int n;
        EI = ex(1, 0, 0, 0, 0, 0, 0, 0);
        EE1 = ex(0, 1, 0, 0, 0, 0, 0, 0);
        EE2 = ex(1, 1, 0, 0, 0, 0, 0, 0);
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 1, 2, 1, 2, 'h00A4, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 'h12345678, 0, 0, 1, 0, ex(1, 0, 0, 1, 0, 'h00A4, 'hF, 'h12345678)));
        tab.push_back(mk(0, 1, 2, 0, 2, 'h0010, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'hCAFEF00D, 0, 0, 0, ex(0, 0, 0, 0, 1, 'h0010, 'hF, 0)));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'hCAFEF00D, 0, 0, 0, ex(0, 0, 0, 0, 1, 'h0010, 'hF, 0)));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'hDEADBEEF, 1, 0, 0, ex(1, 0, 'hDEADBEEF, 0, 1, 'h0010, 'hF, 0)));
        tab.push_back(mk(0, 1, 2, 1, 0, 'h0003, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 'hAA000000, 0, 0, 1, 0, ex(1, 0, 0, 1, 0, 'h0003, 'h8, 'hAA000000)));
        tab.push_back(mk(0, 1, 2, 1, 1, 'h0001, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EE1));
        tab.push_back(mk(0, 1, 2, 1, 3, 'h0000, 0, 0, 0, 0, 0, EE2));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EE1));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EE2));
        tab.push_back(mk(0, 1, 2, 0, 2, 'h0040, 0, 0, 0, 0, 0, EI));
        for (int i = 0; i < 4; i++)
            tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 'h0040, 'hF, 0)));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EE1));
        tab.push_back(mk(0, 1, 2, 1, 2, 'h0050, 0, 0, 0, 0, 0, EE2));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 'h11112222, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 'h0050, 'hF, 'h11112222)));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EE1));
        tab.push_back(mk(0, 1, 2, 1, 2, 'h0020, 0, 0, 0, 0, 0, EE2));
        tab.push_back(mk(0, 1, 2, 0, 2, 'h0024, 'hA5A5A5A5, 0, 0, 1, 0, ex(1, 0, 0, 1, 0, 'h0020, 'hF, 'hA5A5A5A5)));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h55AA55AA, 1, 0, 0, ex(1, 0, 'h55AA55AA, 0, 1, 'h0024, 'hF, 0)));
        tab.push_back(mk(0, 1, 1, 1, 2, 'h0030, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 1, 2, 1, 2, 'h0060, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 'h00000077, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 'h0060, 'hF, 'h77)));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 1, 2, 1, 2, 'h0008, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 'hC0FFEE00, 0, 0, 1, 0, ex(1, 0, 0, 1, 0, 'h0008, 'hF, 'hC0FFEE00)));
        tab.push_back(mk(0, 1, 2, 0, 1, 'h0002, 0, 0, 0, 0, 0, EI));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h12345678, 1, 0, 0, ex(1, 0, 'h12345678, 0, 1, 'h0002, 'hC, 0)));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EI));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EI));
        repeat (2) @(negedge HCLK);
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge HCLK);
            apply(tab[i]);
            exp_q.push_back(tab[i].e);
            #1;
            chk($sformatf("row%0d", i), outs(), exp_q.pop_front());
        end
        @(negedge HCLK);
        apply(mk(0, 1, 2, 0, 2, 'h0044, 0, 0, 0, 0, 0, EI));
        @(negedge HCLK);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EI));
        #1;
        n = 0;
        while (!bus.HRESP && n < 20) begin
            n++;
            @(negedge HCLK);
            #1;
        end
        chk("timeout_waits", 88'(n), 88'd4);
        chk("timeout_err1", {86'd0, bus.HREADYOUT, bus.Read}, 88'd0);
        @(negedge HCLK);
        #1;
        chk("timeout_err2", {86'd0, bus.HREADYOUT, bus.HRESP}, 88'd3);
        @(negedge HCLK);
        #1;
        chk("timeout_idle", outs(), EI);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
